// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: memory map, access-size
// encoding, decoded region type and a byte-merge helper.
package lsu_pkg;

  localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0000_2000;
  localparam int unsigned DMEM_BYTES_DEFAULT = 8192;

  localparam logic [31:0] ADDR_LEDR   = 32'h0000_7000;
  localparam logic [31:0] ADDR_LEDG   = 32'h0000_7010;
  localparam logic [31:0] ADDR_HEX_LO = 32'h0000_7020;
  localparam logic [31:0] ADDR_HEX_HI = 32'h0000_7024;
  localparam logic [31:0] ADDR_LCD    = 32'h0000_7030;
  localparam logic [31:0] ADDR_SW     = 32'h0000_7800;
  localparam logic [31:0] ADDR_KEY    = 32'h0000_7810;

  localparam int unsigned NUM_OUT = 5;

  // funct3 access size/sign encoding
  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_op_e;

  typedef enum logic [1:0] {
    REG_DMEM = 2'd0,
    REG_OUT  = 2'd1,
    REG_IN   = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  // Replace only the byte lanes selected by be
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: word array with byte-enabled synchronous write and
// asynchronous read.
//   clk   - write clock
//   be    - per-byte write enable (0 = no write)
//   idx   - word index
//   wdata - lane-steered write data
//   rdata - word at idx (combinational)
module lsu_dmem #(
  parameter int unsigned WORDS = 2048,
  parameter int unsigned IDX_W = 11
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/lsu.sv
// Load-store unit: decodes the ALU address into data memory, output
// peripheral buffers or sampled inputs; stores commit at posedge clk,
// loads are combinational.
//   clk, rst                  - clock, async active-high reset
//   i_lsu_addr/i_st_data      - byte address and store data
//   i_lsu_wren/i_lsu_op       - store strobe and funct3 size/sign
//   o_ld_data/o_misaligned    - load result and alignment flag (comb)
//   o_io_*                    - registered output peripheral buffers
//   i_io_sw/i_io_key          - input peripherals, sampled every clock
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT,
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_op,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hex_lo,
  output logic [31:0] o_io_hex_hi,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_key
);

  localparam int unsigned DMEM_WORDS = DMEM_BYTES / 4;
  localparam int unsigned IDX_W      = $clog2(DMEM_WORDS);

  logic [1:0]  lane;
  logic [31:0] word_addr;
  logic [31:0] dmem_off;
  region_e     region;
  logic [2:0]  out_idx;
  logic        in_is_key;

  logic        is_b, is_h, is_w, ld_signed, st_legal, access_legal;
  logic        geom_mis;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        st_fire;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;

  logic [31:0] out_q [NUM_OUT];
  logic [31:0] sw_q;
  logic [3:0]  key_q;

  logic [31:0] raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign lane = i_lsu_addr[1:0];

  // Region decode; dmem_off wraps for addresses below the base
  always_comb begin
    word_addr = {i_lsu_addr[31:2], 2'b00};
    dmem_off  = i_lsu_addr - DMEM_BASE;
    region    = REG_NONE;
    out_idx   = 3'd0;
    in_is_key = 1'b0;
    if (dmem_off < 32'(DMEM_BYTES)) begin
      region = REG_DMEM;
    end else begin
      case (word_addr)
        ADDR_LEDR:   begin region = REG_OUT; out_idx = 3'd0; end
        ADDR_LEDG:   begin region = REG_OUT; out_idx = 3'd1; end
        ADDR_HEX_LO: begin region = REG_OUT; out_idx = 3'd2; end
        ADDR_HEX_HI: begin region = REG_OUT; out_idx = 3'd3; end
        ADDR_LCD:    begin region = REG_OUT; out_idx = 3'd4; end
        ADDR_SW:     region = REG_IN;
        ADDR_KEY:    begin region = REG_IN; in_is_key = 1'b1; end
        default:     region = REG_NONE;
      endcase
    end
  end

  // Size/sign decode
  always_comb begin
    is_b      = 1'b0;
    is_h      = 1'b0;
    is_w      = 1'b0;
    ld_signed = 1'b0;
    case (i_lsu_op)
      LSU_B:   begin is_b = 1'b1; ld_signed = 1'b1; end
      LSU_BU:  is_b = 1'b1;
      LSU_H:   begin is_h = 1'b1; ld_signed = 1'b1; end
      LSU_HU:  is_h = 1'b1;
      LSU_W:   is_w = 1'b1;
      default: ;
    endcase
  end

  // Unsigned variants are load-only
  assign st_legal     = (i_lsu_op == LSU_B) || (i_lsu_op == LSU_H) || (i_lsu_op == LSU_W);
  assign access_legal = i_lsu_wren ? st_legal : (is_b | is_h | is_w);
  assign geom_mis     = (is_h & lane[0]) | (is_w & (lane != 2'b00));
  assign o_misaligned = access_legal & geom_mis;

  // Byte enables and lane-replicated store data
  always_comb begin
    be    = 4'b0000;
    wdata = i_st_data;
    if (is_w) begin
      be = 4'b1111;
    end else if (is_h) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{i_st_data[15:0]}};
    end else if (is_b) begin
      be    = 4'b0001 << lane;
      wdata = {4{i_st_data[7:0]}};
    end
  end

  assign st_fire = i_lsu_wren & st_legal & ~geom_mis;
  assign dmem_be = (st_fire && !rst && region == REG_DMEM) ? be : 4'b0000;

  lsu_dmem #(
    .WORDS (DMEM_WORDS),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk   (clk),
    .be    (dmem_be),
    .idx   (dmem_off[IDX_W+1:2]),
    .wdata (wdata),
    .rdata (dmem_rdata)
  );

  // Output buffers and input sample registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
      sw_q  <= '0;
      key_q <= '0;
    end else begin
      sw_q  <= i_io_sw;
      key_q <= i_io_key;
      if (st_fire && region == REG_OUT) begin
        out_q[out_idx] <= merge_bytes(out_q[out_idx], wdata, be);
      end
    end
  end

  assign o_io_ledr   = out_q[0];
  assign o_io_ledg   = out_q[1];
  assign o_io_hex_lo = out_q[2];
  assign o_io_hex_hi = out_q[3];
  assign o_io_lcd    = out_q[4];

  // Load path: region word, lane select, extension
  always_comb begin
    raw = '0;
    case (region)
      REG_DMEM: raw = dmem_rdata;
      REG_OUT:  raw = out_q[out_idx];
      REG_IN:   raw = in_is_key ? {28'd0, key_q} : sw_q;
      default:  raw = '0;
    endcase
    ld_byte   = 8'(raw >> {lane, 3'b000});
    ld_half   = lane[1] ? raw[31:16] : raw[15:0];
    o_ld_data = '0;
    if (!geom_mis && region != REG_NONE) begin
      if (is_b)      o_ld_data = ld_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
      else if (is_h) o_ld_data = ld_signed ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
      else if (is_w) o_ld_data = raw;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-level memory model plus directed vectors.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, st_data, sw;
  logic        wren;
  logic [2:0]  op;
  logic [3:0]  key;
  logic [31:0] ld_data, ledr, ledg, hex_lo, hex_hi, lcd;
  logic        mis;

  int checks = 0;
  int errors = 0;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .i_lsu_addr   (addr),
    .i_st_data    (st_data),
    .i_lsu_wren   (wren),
    .i_lsu_op     (op),
    .o_ld_data    (ld_data),
    .o_misaligned (mis),
    .o_io_ledr    (ledr),
    .o_io_ledg    (ledg),
    .o_io_hex_lo  (hex_lo),
    .o_io_hex_hi  (hex_hi),
    .o_io_lcd     (lcd),
    .i_io_sw      (sw),
    .i_io_key     (key)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [7:0]  m_mem [int];
  logic [31:0] m_out [5];
  logic [31:0] m_sw;
  logic [3:0]  m_key;

  function automatic int out_index(input logic [31:0] a);
    case (a & ~32'h3)
      32'h7000: return 0;
      32'h7010: return 1;
      32'h7020: return 2;
      32'h7024: return 3;
      32'h7030: return 4;
      default:  return -1;
    endcase
  endfunction

  function automatic bit in_dmem(input logic [31:0] a);
    return a >= 32'h2000 && a < 32'h4000;
  endfunction

  function automatic int op_size(input logic [2:0] o, input bit store);
    if (store) return (o == 3'd0) ? 1 : (o == 3'd1) ? 2 : (o == 3'd2) ? 4 : 0;
    case (o)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input int sz);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
  endfunction

  task automatic mload(input logic [31:0] a, input logic [2:0] o,
                       output logic [31:0] v, output bit known);
    int sz;
    logic [7:0] bytes [4];
    logic [31:0] base;
    int oi;
    sz    = op_size(o, 1'b0);
    v     = '0;
    known = 1'b1;
    base  = a & ~32'h3;
    oi    = out_index(a);
    for (int i = 0; i < 4; i++) bytes[i] = 8'h00;
    if (sz == 0 || is_mis(a, sz)) return;
    if (in_dmem(a)) begin
      for (int k = 0; k < sz; k++) begin
        if (m_mem.exists(int'(a) + k)) bytes[a[1:0] + k] = m_mem[int'(a) + k];
        else known = 1'b0;
      end
    end else if (oi >= 0) begin
      for (int i = 0; i < 4; i++) bytes[i] = m_out[oi][8*i +: 8];
    end else if (base == 32'h7800) begin
      for (int i = 0; i < 4; i++) bytes[i] = m_sw[8*i +: 8];
    end else if (base == 32'h7810) begin
      bytes[0] = {4'h0, m_key};
    end else begin
      return;
    end
    for (int k = 0; k < sz; k++) v[8*k +: 8] = bytes[a[1:0] + k];
    if (o == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (o == 3'd1) v = {{16{v[15]}}, v[15:0]};
  endtask

  always @(posedge clk or posedge rst) begin
    int sz, oi;
    logic [31:0] ba;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_out[i] = '0;
      m_sw  = '0;
      m_key = '0;
    end else begin
      if (wren) begin
        sz = op_size(op, 1'b1);
        oi = out_index(addr);
        if (sz != 0 && !is_mis(addr, sz)) begin
          for (int k = 0; k < sz; k++) begin
            ba = addr + 32'(k);
            if (in_dmem(addr))  m_mem[int'(ba)] = st_data[8*k +: 8];
            else if (oi >= 0)   m_out[oi][8*ba[1:0] +: 8] = st_data[8*k +: 8];
          end
        end
      end
      m_sw  = sw;
      m_key = key;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model
  always @(negedge clk) begin
    logic [31:0] exp_ld;
    bit known;
    int sz;
    check("m_ledr", ledr, m_out[0]);
    check("m_ledg", ledg, m_out[1]);
    check("m_hex_lo", hex_lo, m_out[2]);
    check("m_hex_hi", hex_hi, m_out[3]);
    check("m_lcd", lcd, m_out[4]);
    sz = op_size(op, wren);
    check("m_mis", 32'(mis), 32'(sz != 0 && is_mis(addr, sz)));
    if (!wren) begin
      mload(addr, op, exp_ld, known);
      if (known) check("m_ld", ld_data, exp_ld);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [2:0] o);
    @(posedge clk);
    #2;
    addr = a; st_data = d; wren = w; op = o;
  endtask

  initial begin
    rst = 1'b1; addr = '0; st_data = '0; wren = 1'b0; op = 3'd2; sw = '0; key = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ledr", ledr, 32'h0);
    check("rst_lcd", lcd, 32'h0);
    rst = 1'b0;

    // Word store/load
    drive(32'h2000, 32'h1122_3344, 1'b1, 3'd2);
    drive(32'h2004, 32'hDEAD_BEEF, 1'b1, 3'd2);
    drive(32'h2008, 32'h0102_0304, 1'b1, 3'd2);
    drive(32'h2004, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("lw_2004", ld_data, 32'hDEAD_BEEF);
    check("lw_2004_mis", 32'(mis), 32'd0);

    // Byte lanes and extension
    drive(32'h2009, 32'h80, 1'b1, 3'd0);
    drive(32'h2009, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    check("lb_2009", ld_data, 32'hFFFF_FF80);
    drive(32'h2009, 32'h0, 1'b0, 3'd4);
    @(negedge clk);
    check("lbu_2009", ld_data, 32'h0000_0080);
    drive(32'h2008, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("lw_2008", ld_data, 32'h0102_8004);
    drive(32'h200A, 32'h0, 1'b0, 3'd1);
    @(negedge clk);
    check("lh_200a", ld_data, 32'h0000_0102);

    // Misalignment
    drive(32'h2003, 32'h1234, 1'b1, 3'd1);
    @(negedge clk);
    check("sh_2003_mis", 32'(mis), 32'd1);
    drive(32'h2000, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("lw_2000", ld_data, 32'h1122_3344);
    drive(32'h2002, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("lw_2002_ld", ld_data, 32'h0);
    check("lw_2002_mis", 32'(mis), 32'd1);

    // Peripherals
    drive(32'h7000, 32'h0000_00FF, 1'b1, 3'd2);
    drive(32'h7021, 32'h0000_00AA, 1'b1, 3'd0);
    @(negedge clk);
    check("ledr_ff", ledr, 32'h0000_00FF);
    drive(32'h7800, 32'hFFFF_FFFF, 1'b1, 3'd2);
    @(negedge clk);
    check("hex_lo_aa", hex_lo, 32'h0000_AA00);
    drive(32'h7026, 32'h0000_BEEF, 1'b1, 3'd1);
    drive(32'h7030, 32'h0000_0055, 1'b1, 3'd3);
    drive(32'h7026, 32'h0, 1'b0, 3'd5);
    @(negedge clk);
    check("hex_hi", hex_hi, 32'hBEEF_0000);
    check("lcd_illegal", lcd, 32'h0);
    check("lhu_7026", ld_data, 32'h0000_BEEF);
    drive(32'h5000, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("unmapped", ld_data, 32'h0);
    drive(32'h2004, 32'h0, 1'b0, 3'd3);
    @(negedge clk);
    check("illegal_ld", ld_data, 32'h0);

    // Input sampling
    drive(32'h7800, 32'h0, 1'b0, 3'd2);
    sw = 32'h0000_5A5A; key = 4'b1010;
    @(negedge clk);
    check("sw_old", ld_data, 32'h0);
    @(negedge clk);
    check("sw_new", ld_data, 32'h0000_5A5A);
    drive(32'h7810, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("key", ld_data, 32'h0000_000A);

    // Async reset
    drive(32'h7000, 32'hFFFF_FFFF, 1'b1, 3'd2);
    drive(32'h2004, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("ledr_all", ledr, 32'hFFFF_FFFF);
    #1 rst = 1'b1;
    #1 check("async_ledr", ledr, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("dmem_kept", ld_data, 32'hDEAD_BEEF);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
